// File: rtl/keypad_cmd_encoder.sv
// keypad_cmd_encoder: scans a 4x4 active-low matrix keypad, debounces each
// press and emits one 4-bit calculator command per accepted key.
// Build option: define KEYPAD_AUTOREPEAT_EN to add auto-repeat of a held key.
module keypad_cmd_encoder #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLD_CYCLES     = 10,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       busy
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, WAIT_RELEASE} state_e;

  localparam logic [3:0] CMD_IDLE = 4'hF;  // also the code latched for key D
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_cmd_encoder: parameter out of range");
  end

  state_e            state_q, state_d;
  logic [3:0]        col_meta_q, col_s_q;
  logic [1:0]        row_q, row_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        pat_q, pat_d;     // column pattern seen when the key was latched
  logic [3:0]        code_q, code_d;   // decoded command of the latched key

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_armed_q, rpt_armed_d;  // first repeat already issued
`endif

  // Map (row, one-hot-low column) to the calculator command code.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [3:0] col_n);
    logic [1:0] col;
    logic [3:0] code;
    case (col_n)
      4'b1110: col = 2'd0;
      4'b1101: col = 2'd1;
      4'b1011: col = 2'd2;
      default: col = 2'd3;
    endcase
    case ({row, col})
      4'd0:  code = 4'h1;  4'd1:  code = 4'h2;  4'd2:  code = 4'h3;  4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;  4'd5:  code = 4'h5;  4'd6:  code = 4'h6;  4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;  4'd9:  code = 4'h8;  4'd10: code = 4'h9;  4'd11: code = 4'hC;
      4'd12: code = 4'hD;  4'd13: code = 4'h0;  4'd14: code = 4'hE;  default: code = CMD_IDLE;
    endcase
    return code;
  endfunction

  // Registered state: column synchronizer, FSM and its counters.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      state_q    <= SCAN;
      row_q      <= '0;
      div_q      <= '0;
      deb_q      <= '0;
      hold_q     <= '0;
      pat_q      <= 4'hF;
      code_q     <= CMD_IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
`endif
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
      state_q    <= state_d;
      row_q      <= row_d;
      div_q      <= div_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
`endif
    end
  end

  // Next-state logic: scan, debounce, emit and release tracking.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    row_d   = row_q;
    div_d   = div_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    pat_d   = pat_q;
    code_d  = code_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d       = rpt_q;
    rpt_armed_d = rpt_armed_q;
`endif
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          // Only a single low column is a usable press; several low means ghosting.
          if ($onehot(~col_s_q)) begin
            pat_d   = col_s_q;
            code_d  = key_code(row_q, col_s_q);
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (col_s_q == pat_q) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            hold_d  = '0;
            state_d = (code_q == CMD_IDLE) ? WAIT_RELEASE : EMIT;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d   = '0;
          div_d   = '0;
          row_d   = row_q + 2'd1;
          state_d = SCAN;
        end
      end
      EMIT: begin
        // Fixed-length window: column activity is ignored here.
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          deb_d   = '0;
          state_d = WAIT_RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin  // WAIT_RELEASE
        if (col_s_q == 4'hF) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            div_d   = '0;
            row_d   = '0;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (col_s_q == pat_q && code_q != CMD_IDLE) begin
          if (rpt_q == (rpt_armed_q ? PERIOD_LAST : DELAY_LAST)) begin
            rpt_d       = '0;
            rpt_armed_d = 1'b1;
            hold_d      = '0;
            state_d     = EMIT;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          rpt_d       = '0;
          rpt_armed_d = 1'b0;
        end
`endif
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    row_out   = ~(4'b0001 << row_q);
    cmd       = (state_q == EMIT) ? code_q : CMD_IDLE;
    cmd_valid = (state_q == EMIT) && (hold_q == '0);
    busy      = (state_q != SCAN);
  end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// Directed testbench for keypad_cmd_encoder (SCAN_DIV=2, DEBOUNCE=4, HOLD=10).
module tb_keypad_cmd_encoder;

  localparam int SCAN_DIV = 2;
  localparam int DEB      = 4;
  localparam int HOLD     = 10;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int LONG_HOLD  = 40;  // stays below REPEAT_DELAY
  localparam int MUL_PULSES = 6;   // first emit + repeats after 50, then every 20 hold cycles
`else
  localparam int LONG_HOLD  = 100;
  localparam int MUL_PULSES = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in = 4'hF;
  logic [3:0] row_out, cmd;
  logic       cmd_valid, busy;

  always #5 clock = ~clock;

  keypad_cmd_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_DELAY(50), .REPEAT_PERIOD(20)
  ) dut (
    .clock(clock), .reset(reset), .col_in(col_in), .row_out(row_out),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Command stream monitor: pulse count, protocol violations, code runs.
  int         pulse_cnt  = 0;
  int         valid_err  = 0;
  int         direct_err = 0;
  int         run_len    = 0;
  logic [3:0] prev_cmd   = 4'hF;
  logic [3:0] code_q[$];
  int         len_q[$];

  always @(negedge clock) begin
    if (reset) begin
      prev_cmd = 4'hF;
      run_len  = 0;
    end else begin
      if (cmd_valid) pulse_cnt++;
      if (cmd_valid && (cmd == 4'hF || prev_cmd != 4'hF)) valid_err++;
      if (!cmd_valid && cmd != 4'hF && prev_cmd == 4'hF) valid_err++;
      if (prev_cmd != 4'hF && cmd != 4'hF && cmd != prev_cmd) direct_err++;
      if (cmd != 4'hF) run_len++;
      else if (prev_cmd != 4'hF) begin
        code_q.push_back(prev_cmd);
        len_q.push_back(run_len);
        run_len = 0;
      end
      prev_cmd = cmd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clock);
    check("idle_wait", busy, 0);
  endtask

  task automatic wait_row(input int r);
    logic [3:0] want;
    want = ~(4'b0001 << r);
    for (int i = 0; i < 64 && row_out !== want; i++) @(negedge clock);
    check("row_wait", row_out, want);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40 && cmd_valid !== 1'b1; i++) @(negedge clock);
    check("valid_wait", cmd_valid, 1);
  endtask

  // The synchronizer delays col_in by two cycles and a slot is only two
  // cycles long, so the column must go low during the slot of the row
  // before the key's row for the end-of-slot sample to see it there.
  task automatic press(input int r, input int c, input int hold);
    wait_idle();
    wait_row((r + 3) % 4);
    col_in = ~(4'b0001 << c);
    repeat (hold) @(negedge clock);
    col_in = 4'hF;
  endtask

  int         t3_row [5] = '{0, 0, 0, 0, 3};
  int         t3_col [5] = '{0, 1, 3, 2, 2};
  logic [3:0] t3_code[5] = '{4'h1, 4'h2, 4'hA, 4'h3, 4'hE};

  initial begin
    int         base;
    int         busy_hits;
    logic [3:0] exp_row;

    // Reset for one edge, then watch the row rotation.
    @(negedge clock);
    check("rst_row", row_out, 4'b1110);
    check("rst_cmd", cmd, 4'hF);
    check("rst_valid", cmd_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      exp_row = ~(4'b0001 << ((c / 2) % 4));
      check("scan_row", row_out, exp_row);
    end

    // Single press of "1", long hold, release timing.
    wait_idle();
    base = pulse_cnt;
    code_q.delete();
    len_q.delete();
    press(0, 0, LONG_HOLD);
    repeat (5) @(negedge clock);
    check("rel_busy_5", busy, 1);
    @(negedge clock);
    check("rel_busy_6", busy, 0);
    check("rel_row0", row_out, 4'b1110);
    check("k1_pulses", pulse_cnt - base, 1);
    check("k1_runs", code_q.size(), 1);
    check("k1_code", code_q[0], 4'h1);
    check("k1_len", len_q[0], HOLD);

    // Sequence 1, 2, add, 3, equals.
    base = pulse_cnt;
    code_q.delete();
    len_q.delete();
    for (int i = 0; i < 5; i++) press(t3_row[i], t3_col[i], 30);
    wait_idle();
    check("seq_pulses", pulse_cnt - base, 5);
    check("seq_runs", code_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("seq_code", code_q[i], t3_code[i]);
      check("seq_len", len_q[i], HOLD);
    end

    // Three-cycle glitch: debounce aborts, scan resumes at row 1.
    wait_idle();
    base = pulse_cnt;
    wait_row(3);
    col_in = 4'b1110;
    repeat (3) @(negedge clock);
    col_in = 4'hF;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) @(negedge clock);
    check("glitch_busy", busy, 1);
    for (int i = 0; i < 10 && busy !== 1'b0; i++) @(negedge clock);
    check("glitch_scan", busy, 0);
    check("glitch_row1", row_out, 4'b1101);
    repeat (10) @(negedge clock);
    check("glitch_pulses", pulse_cnt - base, 0);

    // Two columns low at once is ghosting and never latches.
    wait_idle();
    base = pulse_cnt;
    busy_hits = 0;
    col_in = 4'b1100;
    repeat (40) begin
      @(negedge clock);
      if (busy) busy_hits++;
    end
    col_in = 4'hF;
    check("ghost_busy", busy_hits, 0);
    check("ghost_pulses", pulse_cnt - base, 0);

    // Reset during the emit of "5".
    wait_idle();
    base = pulse_cnt;
    wait_row(0);
    col_in = 4'b1101;
    wait_valid();
    check("k5_code", cmd, 4'h5);
    @(negedge clock);
    reset  = 1'b1;
    col_in = 4'hF;
    @(negedge clock);
    check("abort_cmd", cmd, 4'hF);
    check("abort_row", row_out, 4'b1110);
    check("abort_valid", cmd_valid, 0);
    check("abort_busy", busy, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    check("abort_pulses", pulse_cnt - base, 1);

    // Hold "mul" for 200 cycles.
    base = pulse_cnt;
    press(2, 3, 200);
    repeat (30) @(negedge clock);
    check("mul_pulses", pulse_cnt - base, MUL_PULSES);
    check("mul_code", code_q[code_q.size() - 1], 4'hC);
    check("mul_idle", busy, 0);

    check("valid_protocol", valid_err, 0);
    check("no_direct_change", direct_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_cmd_encoder.md
Name: keypad_cmd_encoder

Overview:
Upstream stage of calc_top. Scans a 4x4 matrix keypad, debounces presses and emits one 4-bit calculator command per press on cmd. cmd drives calc_top.cmd directly and rests at the idle code between presses.

Parameters:
SCAN_DIV, 16, clock cycles each row stays driven during scanning (>=2)
DEBOUNCE_CYCLES, 8, consecutive stable cycles needed to accept a press or a release (>=1)
HOLD_CYCLES, 10, cycles cmd holds a command code before returning to idle (>=1)
REPEAT_DELAY, 500, cycles a key must stay held before the first auto-repeat (used only with the optional feature)
REPEAT_PERIOD, 100, cycles between later auto-repeats (used only with the optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
col_in  in  4  keypad columns, active-low, pulled up externally, asynchronous to clock
row_out  out  4  keypad row drive, active-low, exactly one bit low at any time
cmd  out  4  command to calc_top: 0-9 digit, 1010 add, 1011 sub, 1100 mul, 1101 clear, 1110 equals, 1111 idle
cmd_valid  out  1  one-cycle pulse on the first cycle a new code appears on cmd
busy  out  1  high outside SCAN (a key is being processed)

Behaviour:
- One clock. reset is synchronous and active-high; every register is updated only on the rising edge of clock.
- Reset values: row_out=1110, cmd=1111, cmd_valid=0, busy=0, FSM=SCAN, row index=0, all counters=0. Reset asserted mid-operation aborts any emit or repeat on the next edge.
- col_in passes through a 2-flop synchronizer. All FSM decisions use the synchronized value, col_s, which adds 2 cycles of latency.
- Key map (row,col): r0: 1,2,3,add; r1: 4,5,6,sub; r2: 7,8,9,mul; r3: clear,0,equals,D. Key D (r3,c3) emits nothing.
- FSM states:
  SCAN: row index advances 0->1->2->3->0, one row per SCAN_DIV cycles; row_out = ~(1<<row). col_s is sampled on the last cycle of each row slot.
    * exactly one col_s bit low -> latch (row,col), go to DEBOUNCE with the row frozen.
    * zero or more than one bit low (ghosting) -> keep scanning.
  DEBOUNCE: counts cycles with col_s equal to the latched pattern.
    * mismatch -> back to SCAN, continuing at the next row.
    * count reaches DEBOUNCE_CYCLES -> EMIT, or WAIT_RELEASE if the key is D.
  EMIT: cmd = decoded code for exactly HOLD_CYCLES cycles; cmd_valid=1 on the first of them only. Then cmd=1111 and go to WAIT_RELEASE.
  WAIT_RELEASE: row stays frozen. Need col_s==1111 for DEBOUNCE_CYCLES consecutive cycles; any low bit restarts the count. Then go to SCAN at row 0.
- Press-to-cmd latency from stable col_in: 2 (sync) + up to 4*SCAN_DIV (scan) + DEBOUNCE_CYCLES + 1.
- Pressing a second key while the first is held has no effect; only the latched key matters until release.
- A press shorter than DEBOUNCE_CYCLES emits nothing.
- Releasing the key during EMIT does not shorten the HOLD_CYCLES window.
- cmd never changes directly from one command code to another without at least one cycle of 1111 in between.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in WAIT_RELEASE, a key held continuously for REPEAT_DELAY cycles re-enters EMIT with the same code. After each emit, a further REPEAT_PERIOD cycles of hold triggers another emit. Any release cancels the repeat counter. Key D never repeats.
- Undefined: no repeat logic is synthesized and REPEAT_* are ignored; one press gives exactly one command.

Test Plan:
All scenarios use SCAN_DIV=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10 unless noted.
1. Reset held 1 cycle, no keys -> row_out=1110, cmd=1111, cmd_valid=0, busy=0; row_out then rotates 1110,1101,1011,0111 every 2 cycles.
2. Press key "1" (col0 low while row0 driven), hold 100 cycles, release -> cmd=0001 for exactly 10 cycles, one cmd_valid pulse, then 1111; busy drops 6 cycles after release.
3. Sequence 1, 2, add, 3, equals, releasing between each -> cmd codes 0001, 0010, 1010, 0011, 1110 in that order, five cmd_valid pulses, each code separated by idle 1111.
4. Glitch: col0 low for 3 cycles during row0, then high -> no cmd_valid, FSM back in SCAN, scan continues at row1.
5. Two columns low on the same row -> ignored, no emit. Reset asserted during EMIT of "5" -> next cycle cmd=1111, row_out=1110.
6. With KEYPAD_AUTOREPEAT_EN, REPEAT_DELAY=50, REPEAT_PERIOD=20, hold "mul" for 200 cycles -> first 1100 emit, then repeats roughly 50 cycles after the first emit and every 20 hold cycles after each emit, each with one cmd_valid pulse. Without the macro, the same stimulus gives exactly one pulse.
